// File: rtl/alu_16b.sv
// alu_16b: registered 16-bit ALU for the execute stage.
// Optional: define ALU16B_OVERFLOW_EN to add the Overflow output.
module alu_16b #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] ALUScrA,
  input  logic [WIDTH-1:0] ALUScrB,
  input  logic [2:0]       Op,
  output logic [WIDTH-1:0] O,
  output logic             Zero
`ifdef ALU16B_OVERFLOW_EN
  ,
  output logic             Overflow
`endif
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] dif_d;
  logic [WIDTH-1:0] sh_d;
  logic [WIDTH-1:0] f_d;
  logic [3:0]       amt_d;
  logic             slt_d;

  logic [WIDTH-1:0] o_q;
  logic             zero_q;

  assign amt_d = ALUScrB[3:0];
  assign sum_d = ALUScrA + ALUScrB;
  assign dif_d = ALUScrA - ALUScrB;
  assign slt_d = $signed(ALUScrA) < $signed(ALUScrB);

  // Shift unit: B[6] picks direction, B[5] picks arithmetic right.
  always_comb begin
    sh_d = ALUScrA;
    if (!ALUScrB[6]) begin
      sh_d = ALUScrA << amt_d;
    end else if (ALUScrB[5]) begin
      sh_d = WIDTH'($signed(ALUScrA) >>> amt_d);
    end else begin
      sh_d = ALUScrA >> amt_d;
    end
  end

  // Result select; every opcode is defined.
  always_comb begin
    f_d = '0;
    unique case (Op)
      3'b000: f_d = ALUScrA & ALUScrB;
      3'b001: f_d = ALUScrA ^ ALUScrB;
      3'b010: f_d = ALUScrA | ALUScrB;
      3'b011: f_d = ~(ALUScrA | ALUScrB);
      3'b100: f_d = sum_d;
      3'b101: f_d = dif_d;
      3'b110: f_d = sh_d;
      3'b111: f_d = {{(WIDTH-1){1'b0}}, slt_d};
      default: f_d = '0;
    endcase
  end

  // Capture result and zero flag; reset forces a zero result.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      o_q    <= '0;
      zero_q <= 1'b1;
    end else begin
      o_q    <= f_d;
      zero_q <= (f_d == '0);
    end
  end

  assign O    = o_q;
  assign Zero = zero_q;

`ifdef ALU16B_OVERFLOW_EN
  logic ovf_d;
  logic ovf_q;

  // Signed overflow: operand signs vs result sign.
  always_comb begin
    ovf_d = 1'b0;
    if (Op == 3'b100) begin
      ovf_d = (ALUScrA[MSB] == ALUScrB[MSB]) &&
              (sum_d[MSB] != ALUScrA[MSB]);
    end else if (Op == 3'b101) begin
      ovf_d = (ALUScrA[MSB] != ALUScrB[MSB]) &&
              (dif_d[MSB] != ALUScrA[MSB]);
    end
  end

  // Overflow registered alongside O.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu_16b.sv
// tb_alu_16b: directed vectors plus a reference model for alu_16b.
// Define ALU16B_OVERFLOW_EN to also check the Overflow output.
module tb_alu_16b;

  logic        CLK;
  logic        Reset;
  logic [15:0] ALUScrA;
  logic [15:0] ALUScrB;
  logic [2:0]  Op;
  logic [15:0] O;
  logic        Zero;
`ifdef ALU16B_OVERFLOW_EN
  logic        Overflow;
`endif

  int n_pass = 0;
  int n_total = 0;
  bit cmp_en = 0;

  logic [15:0] m_o;
  logic        m_v;

  alu_16b #(.WIDTH(16)) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .ALUScrA (ALUScrA),
    .ALUScrB (ALUScrB),
    .Op      (Op),
    .O       (O),
    .Zero    (Zero)
`ifdef ALU16B_OVERFLOW_EN
    ,
    .Overflow(Overflow)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int sval(input logic [15:0] x);
    return (x >= 16'h8000) ? int'(x) - 65536 : int'(x);
  endfunction

  // Reference result from the arithmetic meaning of each opcode.
  function automatic logic [15:0] model(input logic [2:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    int r;
    logic [15:0] s;
    r = 0;
    case (op)
      3'd0: r = int'(a & b);
      3'd1: r = int'(a ^ b);
      3'd2: r = int'(a | b);
      3'd3: r = 65535 - int'(a | b);
      3'd4: r = (int'(a) + int'(b)) % 65536;
      3'd5: r = (int'(a) - int'(b) + 65536) % 65536;
      3'd6: begin
        s = a;
        for (int i = 0; i < int'(b[3:0]); i++) begin
          if (!b[6]) s = {s[14:0], 1'b0};
          else if (b[5]) s = {s[15], s[15:1]};
          else s = {1'b0, s[15:1]};
        end
        r = int'(s);
      end
      default: r = (sval(a) < sval(b)) ? 1 : 0;
    endcase
    return 16'(r);
  endfunction

  function automatic logic model_ovf(input logic [2:0] op,
                                     input logic [15:0] a,
                                     input logic [15:0] b);
    int t;
    if (op == 3'd4) t = sval(a) + sval(b);
    else if (op == 3'd5) t = sval(a) - sval(b);
    else t = 0;
    return (t > 32767) || (t < -32768);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Model follows the register: cleared by reset, loads on each edge.
  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      m_o <= 16'h0000;
      m_v <= 1'b0;
    end else begin
      m_o <= model(Op, ALUScrA, ALUScrB);
      m_v <= model_ovf(Op, ALUScrA, ALUScrB);
    end
  end

  // Every falling edge: DUT against the model.
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("model_O", int'(O), int'(m_o));
      chk("model_Zero", int'(Zero), int'(m_o == 16'h0));
`ifdef ALU16B_OVERFLOW_EN
      chk("model_Ovf", int'(Overflow), int'(m_v));
`endif
    end
  end

  // Drive one vector, then check the captured literal expectation.
  task automatic vec(input string nm, input logic [2:0] op,
                     input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] exp);
    Op = op;
    ALUScrA = a;
    ALUScrB = b;
    @(posedge CLK);
    #1;
    chk(nm, int'(O), int'(exp));
    chk({nm, "_z"}, int'(Zero), int'(exp == 16'h0));
  endtask

  initial begin
    Reset = 1'b0;
    Op = 3'd0;
    ALUScrA = 16'h0;
    ALUScrB = 16'h0;
    #1 Reset = 1'b1;
    #1;
    chk("rst_O", int'(O), 0);
    chk("rst_Zero", int'(Zero), 1);
`ifdef ALU16B_OVERFLOW_EN
    chk("rst_Ovf", int'(Overflow), 0);
`endif
    @(posedge CLK);
    @(posedge CLK);
    #2 Reset = 1'b0;
    cmp_en = 1;

    vec("and_8888", 3'd0, 16'hFFFF, 16'h8888, 16'h8888);
    vec("and_zero", 3'd0, 16'hFFFF, 16'h0000, 16'h0000);
    vec("or_ffff",  3'd2, 16'hEEEE, 16'h1111, 16'hFFFF);
    vec("xor_f0f0", 3'd1, 16'hFF00, 16'h0FF0, 16'hF0F0);
    vec("nor_ffff", 3'd3, 16'h0000, 16'h0000, 16'hFFFF);
    vec("add_wrap", 3'd4, 16'hFFFF, 16'h0001, 16'h0000);
    vec("sub_wrap", 3'd5, 16'h0001, 16'h0002, 16'hFFFF);
    vec("sub_zero", 3'd5, 16'h0001, 16'h0001, 16'h0000);
    vec("add_ovf",  3'd4, 16'h7FFF, 16'h0001, 16'h8000);
`ifdef ALU16B_OVERFLOW_EN
    chk("ovf_add", int'(Overflow), 1);
    vec("sub_ovf",  3'd5, 16'h8000, 16'h0001, 16'h7FFF);
    chk("ovf_sub", int'(Overflow), 1);
    vec("sub_nov",  3'd5, 16'h0001, 16'h0002, 16'hFFFF);
    chk("ovf_none", int'(Overflow), 0);
`endif
    vec("slt_neg",  3'd7, 16'h8000, 16'hFFFF, 16'h0001);
    vec("slt_zm1",  3'd7, 16'h0000, 16'hFFFF, 16'h0000);
    vec("slt_10",   3'd7, 16'h0001, 16'h0000, 16'h0000);
    vec("slt_ovf",  3'd7, 16'h8000, 16'h7FFF, 16'h0001);
    vec("shl_1",    3'd6, 16'h0001, 16'h0001, 16'h0002);
    vec("shl_0",    3'd6, 16'h0000, 16'h0001, 16'h0000);
    vec("shr_2",    3'd6, 16'h0002, 16'h0041, 16'h0001);
    vec("shr_ff",   3'd6, 16'hFFFF, 16'h0041, 16'h7FFF);
    vec("sra_ff",   3'd6, 16'hFFFF, 16'h0061, 16'hFFFF);
    vec("sra_15",   3'd6, 16'h8000, 16'h006F, 16'hFFFF);
    vec("sh_amt0",  3'd6, 16'h1234, 16'hFF80, 16'h1234);
    vec("shl_15",   3'd6, 16'h0003, 16'h002F, 16'h8000);
    vec("shr_4",    3'd6, 16'hF0F0, 16'h0044, 16'h0F0F);
    vec("sra_4",    3'd6, 16'hF0F0, 16'h0064, 16'hFF0F);

    // Reset mid-cycle clears O with no clock edge.
    vec("pre_rst",  3'd2, 16'h1234, 16'h0000, 16'h1234);
    #2 Reset = 1'b1;
    #1;
    chk("async_O", int'(O), 0);
    chk("async_Z", int'(Zero), 1);
    @(posedge CLK);
    #1;
    chk("hold_O", int'(O), 0);
    chk("hold_Z", int'(Zero), 1);
    #1 Reset = 1'b0;
    vec("post_rst", 3'd4, 16'h0001, 16'h0001, 16'h0002);

    // Inputs changing between edges must not disturb O.
    vec("lat_a",    3'd1, 16'hAAAA, 16'h0F0F, 16'hA5A5);
    Op = 3'd4;
    ALUScrA = 16'h0100;
    ALUScrB = 16'h0023;
    #3;
    chk("lat_hold", int'(O), 16'hA5A5);
    Op = 3'd0;
    ALUScrA = 16'h00FF;
    ALUScrB = 16'h0F0F;
    #2;
    chk("lat_hold2", int'(O), 16'hA5A5);
    @(posedge CLK);
    #1;
    chk("lat_new", int'(O), 16'h000F);

    // Extra operand mixes checked by the model process.
    for (int i = 0; i < 48; i++) begin
      Op = 3'(i % 8);
      ALUScrA = 16'($urandom);
      ALUScrB = 16'($urandom);
      @(posedge CLK);
      #1;
    end

    @(negedge CLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
